// File: rtl/pipe_ctrl.sv
// Pipeline control unit: merges stage stall requests into a monotone hold vector,
// sequences branch-mispredict recovery (discard + PC redirect) and keeps perf counters.
module pipe_ctrl (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        if_stall_req,
  input  logic        id_stall_req,
  input  logic        mem_stall_req,
  input  logic        ex_mispredict,
  input  logic [31:0] ex_target,
  input  logic        if_busy,
  input  logic        cnt_clear,
  output logic [5:0]  stall,
  output logic        discard,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
);

  localparam int unsigned MemAddrBus = 32;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [MemAddrBus-1:0] tgt_q, tgt_d;
  logic [31:0]           stall_cnt_q, stall_cnt_d;
  logic [31:0]           flush_cnt_q, flush_cnt_d;
  logic                  accept;

  // Highest requesting stage wins; everything upstream of it holds too.
  always_comb begin
    if (mem_stall_req)     stall = 6'b011111;
    else if (id_stall_req) stall = 6'b000111;
    else if (if_stall_req) stall = 6'b000011;
    else                   stall = 6'b000000;
  end

  // A mispredict from a held EX stage is stale; EX re-presents it later.
  assign accept = ex_mispredict && !stall[3];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d        = state_q;
    tgt_d          = tgt_q;
    redirect_valid = 1'b0;
    case (state_q)
      IDLE: ;
      PEND: begin
        if (!if_busy) begin
          redirect_valid = 1'b1;
          state_d        = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // A newer accept overrides the redirect just issued from the old target.
    if (accept) begin
      state_d = PEND;
      tgt_d   = ex_target;
    end
  end

  assign discard     = accept || (state_q == PEND);
  assign redirect_pc = tgt_q;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (cnt_clear) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if ((|stall) && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 32'd1;
      if (accept && (flush_cnt_q != '1))   flush_cnt_d = flush_cnt_q + 32'd1;
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign flush_count  = flush_cnt_q;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      tgt_q       <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      tgt_q       <= tgt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_pipe_ctrl;

  localparam longint CntMax = 64'h0000_0000_FFFF_FFFF;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        if_stall_req, id_stall_req, mem_stall_req;
  logic        ex_mispredict;
  logic [31:0] ex_target;
  logic        if_busy, cnt_clear;
  logic [5:0]  stall;
  logic        discard, redirect_valid;
  logic [31:0] redirect_pc, stall_cycles, flush_count;

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model state: is a redirect owed, to where, and the two counts.
  bit          m_pend;
  logic [31:0] m_tgt;
  longint      m_sc, m_fc;

  pipe_ctrl dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .if_stall_req   (if_stall_req),
    .id_stall_req   (id_stall_req),
    .mem_stall_req  (mem_stall_req),
    .ex_mispredict  (ex_mispredict),
    .ex_target      (ex_target),
    .if_busy        (if_busy),
    .cnt_clear      (cnt_clear),
    .stall          (stall),
    .discard        (discard),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall_cycles   (stall_cycles),
    .flush_count    (flush_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    else n_pass++;
  endtask

  // Number of held stages is set by the highest requester; the vector is that many ones.
  function automatic logic [5:0] exp_stall();
    int held;
    held = mem_stall_req ? 5 : id_stall_req ? 3 : if_stall_req ? 2 : 0;
    return 6'((1 << held) - 1);
  endfunction

  function automatic bit exp_accept();
    logic [5:0] s;
    s = exp_stall();
    return ex_mispredict && !s[3];
  endfunction

  task automatic mdl_reset();
    m_pend = 1'b0;
    m_tgt  = '0;
    m_sc   = 0;
    m_fc   = 0;
  endtask

  task automatic mdl_update();
    bit acc;
    acc = exp_accept();
    if (!reset_n) begin
      mdl_reset();
    end else begin
      if (cnt_clear) begin
        m_sc = 0;
        m_fc = 0;
      end else begin
        if (exp_stall() != 6'd0) m_sc = (m_sc + 1 > CntMax) ? CntMax : m_sc + 1;
        if (acc)                 m_fc = (m_fc + 1 > CntMax) ? CntMax : m_fc + 1;
      end
      if (acc) begin
        m_pend = 1'b1;
        m_tgt  = ex_target;
      end else if (m_pend && !if_busy) begin
        m_pend = 1'b0;
      end
    end
  endtask

  task automatic cmp_all();
    bit rv;
    rv = m_pend && !if_busy;
    check("stall", 32'(stall), 32'(exp_stall()));
    check("discard", 32'(discard), 32'(exp_accept() || m_pend));
    check("redirect_valid", 32'(redirect_valid), 32'(rv));
    if (rv) check("redirect_pc", redirect_pc, m_tgt);
    check("stall_cycles", stall_cycles, 32'(m_sc));
    check("flush_count", flush_count, 32'(m_fc));
  endtask

  task automatic sample();
    @(negedge clock);
    cmp_all();
  endtask

  task automatic next_cycle();
    @(posedge clock);
    mdl_update();
    #1;
  endtask

  task automatic idle_inputs();
    if_stall_req  = 1'b0;
    id_stall_req  = 1'b0;
    mem_stall_req = 1'b0;
    ex_mispredict = 1'b0;
    ex_target     = '0;
    if_busy       = 1'b0;
    cnt_clear     = 1'b0;
  endtask

  task automatic clear_cycle();
    idle_inputs();
    cnt_clear = 1'b1;
    sample();
    next_cycle();
    cnt_clear = 1'b0;
  endtask

  initial begin
    logic [5:0] prio_tbl [1:7];
    int         rv_seen;
    prio_tbl = '{6'h03, 6'h07, 6'h07, 6'h1F, 6'h1F, 6'h1F, 6'h1F};

    // Reset, including an abandoned pending redirect.
    reset_n = 1'b0;
    idle_inputs();
    mdl_reset();
    sample(); next_cycle();
    sample(); next_cycle();
    reset_n = 1'b1;
    ex_mispredict = 1'b1; ex_target = 32'h0000_0ABC; if_busy = 1'b1;
    sample();
    check("pre_reset_discard", 32'(discard), 32'd1);
    next_cycle();
    ex_mispredict = 1'b0;
    sample();
    #1 reset_n = 1'b0;
    mdl_reset();
    next_cycle();
    sample(); next_cycle();
    reset_n = 1'b1;
    if_busy = 1'b0;
    for (int c = 0; c < 3; c++) begin
      sample();
      check("rst_stall", 32'(stall), 32'd0);
      check("rst_discard", 32'(discard), 32'd0);
      check("rst_redirect_valid", 32'(redirect_valid), 32'd0);
      check("rst_redirect_pc", redirect_pc, 32'd0);
      check("rst_stall_cycles", stall_cycles, 32'd0);
      check("rst_flush_count", flush_count, 32'd0);
      next_cycle();
    end

    // Stall priority over all seven request combinations.
    clear_cycle();
    for (int i = 1; i <= 7; i++) begin
      logic [2:0] r;
      r = 3'(i);
      if_stall_req = r[0]; id_stall_req = r[1]; mem_stall_req = r[2];
      sample();
      check("prio_stall", 32'(stall), 32'(prio_tbl[i]));
      next_cycle();
    end
    idle_inputs();
    sample();
    check("prio_stall_cycles", stall_cycles, 32'd7);
    next_cycle();

    // Clean redirect.
    clear_cycle();
    ex_mispredict = 1'b1; ex_target = 32'h0000_1000;
    sample();
    check("clean_discard_c1", 32'(discard), 32'd1);
    check("clean_rv_c1", 32'(redirect_valid), 32'd0);
    next_cycle();
    ex_mispredict = 1'b0;
    sample();
    check("clean_discard_c2", 32'(discard), 32'd1);
    check("clean_rv_c2", 32'(redirect_valid), 32'd1);
    check("clean_pc", redirect_pc, 32'h0000_1000);
    check("clean_flush_count", flush_count, 32'd1);
    next_cycle();
    sample();
    check("clean_discard_c3", 32'(discard), 32'd0);
    check("clean_rv_c3", 32'(redirect_valid), 32'd0);
    next_cycle();

    // Busy IF: three busy cycles while pending stretch the redirect to cycle 5.
    clear_cycle();
    rv_seen = 0;
    for (int c = 1; c <= 6; c++) begin
      ex_mispredict = (c == 1);
      ex_target     = 32'h0000_0200;
      if_busy       = (c <= 4);
      sample();
      check("busy_discard", 32'(discard), 32'(c <= 5));
      check("busy_rv", 32'(redirect_valid), 32'(c == 5));
      if (redirect_valid) begin
        rv_seen++;
        check("busy_pc", redirect_pc, 32'h0000_0200);
      end
      next_cycle();
    end
    check("busy_rv_count", 32'(rv_seen), 32'd1);
    idle_inputs();

    // Mispredict blocked by a MEM hold, accepted once the hold drops.
    clear_cycle();
    for (int c = 1; c <= 5; c++) begin
      ex_mispredict = (c <= 3);
      mem_stall_req = (c <= 2);
      ex_target     = 32'h0000_0300;
      sample();
      check("blk_discard", 32'(discard), 32'(c == 3 || c == 4));
      check("blk_rv", 32'(redirect_valid), 32'(c == 4));
      if (c == 4) check("blk_pc", redirect_pc, 32'h0000_0300);
      if (c == 5) check("blk_flush_count", flush_count, 32'd1);
      next_cycle();
    end
    idle_inputs();

    // Saturation and clear.
    sample();
    #1;
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    force dut.flush_cnt_q = 32'hFFFF_FFFE;
    m_sc = 64'h0000_0000_FFFF_FFFE;
    m_fc = 64'h0000_0000_FFFF_FFFE;
    #1;
    release dut.stall_cnt_q;
    release dut.flush_cnt_q;
    next_cycle();
    for (int c = 0; c < 3; c++) begin
      if_stall_req = 1'b1; ex_mispredict = 1'b1; ex_target = 32'h0000_4000 + 32'(c * 4);
      sample();
      next_cycle();
    end
    idle_inputs();
    sample();
    check("sat_stall_cycles", stall_cycles, 32'hFFFF_FFFF);
    check("sat_flush_count", flush_count, 32'hFFFF_FFFF);
    next_cycle();
    cnt_clear = 1'b1; if_stall_req = 1'b1;
    sample();
    next_cycle();
    idle_inputs();
    sample();
    check("clr_stall_cycles", stall_cycles, 32'd0);
    check("clr_flush_count", flush_count, 32'd0);
    next_cycle();

    // Randomized traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      mem_stall_req = ($urandom_range(7) == 0);
      id_stall_req  = ($urandom_range(5) == 0);
      if_stall_req  = ($urandom_range(4) == 0);
      ex_mispredict = ($urandom_range(3) == 0);
      ex_target     = {$urandom(), 2'b00} >> 2 << 2;
      if_busy       = $urandom_range(1) == 1;
      cnt_clear     = ($urandom_range(49) == 0);
      sample();
      next_cycle();
    end
    idle_inputs();
    sample();
    next_cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
